timer_count_core: RTL and testbench
===================================

// Module: timer_count_core
// PURPOSE
//  Sequential count engine of the two-mode timer: produces the raw 0..MAX_COUNT count that feeds
//  the Reverser (RevIn). Always counts up; ModeSel is latched at start and forwarded so the
//  Reverser shows up-count (pass-through) or down-count (MAX_COUNT - count). Contains tick
//  prescaler, start/pause/clear control FSM and terminal-count detection.
// PARAMETERS
//  WIDTH      8    count/output width; MAX_COUNT < 2**WIDTH required
//  MAX_COUNT  99   terminal count (displays 99 in up mode, 0 in down mode)
//  TICK_DIV   100  Clk cycles per count step; >=1 (1 = step every running cycle)
// PORTS
//  Clk         in   1      system clock, all logic on rising edge
//  Reset       in   1      synchronous, active-high; highest priority
//  Start       in   1      level-sampled each cycle: start/resume
//  Stop        in   1      level-sampled each cycle: pause
//  Clear       in   1      return to IDLE, count 0
//  ModeSelIn   in   1      0 = up-count, 1 = down-count; sampled only on IDLE/DONE->RUN
//  CountOut    out  WIDTH  raw count, drives Reverser RevIn
//  ModeSel     out  1      latched mode, drives Reverser ModeSel
//  Running     out  1      1 while state == RUN
//  Done        out  1      one-cycle pulse on the edge CountOut becomes MAX_COUNT
//  Expired     out  1      level, 1 while state == DONE
// BEHAVIOUR
//  - One clock (Clk); Reset is synchronous, active-high. Reset -> state IDLE, CountOut=0,
//    ModeSel=0, prescaler=0, Running=0, Done=0, Expired=0. Reset mid-run discards everything.
//  - States: IDLE, RUN, PAUSE, DONE (2-bit encoding). Priority per cycle: Reset > Clear > Stop > Start.
//  - IDLE: Start -> RUN, CountOut=0, prescaler=0, ModeSel<=ModeSelIn.
//  - RUN: Stop -> PAUSE (prescaler and count held). Else prescaler increments; when
//    prescaler==TICK_DIV-1 it resets to 0 and CountOut increments on the same edge.
//  - First step: CountOut=1 exactly TICK_DIV cycles after the Start edge.
//  - PAUSE: Start (and no Stop) -> RUN, resuming with preserved prescaler phase; ModeSel unchanged.
//  - Terminal: the step from MAX_COUNT-1 to MAX_COUNT asserts Done for one cycle and moves to DONE.
//  - DONE: CountOut held at MAX_COUNT, Expired=1; Start -> same as IDLE Start (restart from 0).
//  - Clear in any state -> IDLE, CountOut=0, prescaler=0, Done=0; ModeSel retained.
//  - Start+Stop same cycle: Stop wins (RUN->PAUSE, IDLE/PAUSE/DONE stay). Clear+tick: Clear wins.
//  - ModeSelIn changes while RUN/PAUSE are ignored until next start from IDLE/DONE.
//  - CountOut never exceeds MAX_COUNT; no intermediate value skipped.
//  - All outputs registered; no combinational path input->output.
// CONFIGURATION
//  TIMER_AUTO_RELOAD_EN defined: at terminal step Done pulses but state stays RUN and the
//    next step wraps CountOut MAX_COUNT->0 (prescaler phase continuous); Expired stays 0; DONE
//    unreachable.
//  Undefined: stop in DONE as described above.
// TESTING (WIDTH=8, MAX_COUNT=99, TICK_DIV=4 unless noted)
//  1. Reset, Start pulse, ModeSelIn=0 -> CountOut=1 after 4 cycles, 2 after 8; Running=1, ModeSel=0.
//  2. Run to end -> CountOut=99 at cycle 396, Done high exactly 1 cycle, Expired=1, count holds 99
//     for 20 further cycles; with TIMER_AUTO_RELOAD_EN CountOut=0 at cycle 400, Expired=0.
//  3. Stop at cycle 10 (count 2, prescaler 2), hold 7 cycles, Start -> count 3 after 1 more cycle
//     (phase preserved); Running=0 during pause.
//  4. Start+Stop same cycle in RUN -> PAUSE; in IDLE -> stays IDLE, CountOut=0.
//  5. ModeSelIn=1 at Start, toggle to 0 mid-run -> ModeSel stays 1; Clear then Start with
//     ModeSelIn=0 -> ModeSel=0, CountOut restarts at 0.
//  6. Reset asserted at count 50 in RUN -> next edge all outputs reset values; TICK_DIV=1 build
//     -> CountOut increments every running cycle.

Source files
------------

// File: rtl/timer_count_core.sv
// Count engine of the two-mode timer: prescaled up-counter with start/pause/clear control.
// Optional build macro TIMER_AUTO_RELOAD_EN: wrap to 0 after MAX_COUNT instead of stopping in DONE.
module timer_count_core #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 99,
  parameter int TICK_DIV  = 100
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Clear,
  input  logic             ModeSelIn,
  output logic [WIDTH-1:0] CountOut,
  output logic             ModeSel,
  output logic             Running,
  output logic             Done,
  output logic             Expired,
  output logic [1:0]       dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] COUNT_PRE  = WIDTH'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             step_en;

  // A running cycle advances the prescaler; a resume edge out of PAUSE counts as running.
  always_comb begin
    step_en = 1'b0;
    if (!Clear && !Stop) begin
      if (state_q == RUN)              step_en = 1'b1;
      else if (state_q == PAUSE && Start) step_en = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (Start && !Stop) begin
            state_d = RUN;
            count_d = '0;
            presc_d = '0;
            mode_d  = ModeSelIn;
          end
        end
        RUN: begin
          if (Stop) state_d = PAUSE;
        end
        PAUSE: begin
          if (Start && !Stop) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
      if (step_en) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (count_q == COUNT_MAX) begin
            count_d = '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
          if (count_q == COUNT_PRE) begin
            done_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Outputs are flops or pure decodes of the state flop; no input reaches them combinationally.
  assign CountOut  = count_q;
  assign ModeSel   = mode_q;
  assign Done      = done_q;
  assign Running   = (state_q == RUN);
  assign Expired   = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_count_core.sv
// Directed bench for timer_count_core: TICK_DIV=4 main instance plus a TICK_DIV=1 instance.
module tb_timer_count_core;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear, mode_in;
  logic [7:0] count_o, count1_o;
  logic       mode_o, run_o, done_o, exp_o;
  logic       mode1_o, run1_o, done1_o, exp1_o;
  logic [1:0] st_o, st1_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  timer_count_core #(.WIDTH(8), .MAX_COUNT(99), .TICK_DIV(4)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Stop(stop), .Clear(clear),
    .ModeSelIn(mode_in), .CountOut(count_o), .ModeSel(mode_o), .Running(run_o),
    .Done(done_o), .Expired(exp_o), .dbg_state(st_o)
  );

  timer_count_core #(.WIDTH(8), .MAX_COUNT(99), .TICK_DIV(1)) dut1 (
    .Clk(clk), .Reset(reset), .Start(start), .Stop(stop), .Clear(clear),
    .ModeSelIn(mode_in), .CountOut(count1_o), .ModeSel(mode1_o), .Running(run1_o),
    .Done(done1_o), .Expired(exp1_o), .dbg_state(st1_o)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, obs}, {24'd0, e});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode_in = 1'b0;
    tick(2);
    check("rst_count", count_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_running", run_o, 0);
    check("rst_done", done_o, 0);
    check("rst_expired", exp_o, 0);
    check("rst_state", st_o, 0);
    reset = 1'b0;

    // Start from IDLE, up mode; first step exactly TICK_DIV edges after the start edge.
    mode_in = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_running", run_o, 1);
    check("t1_mode", mode_o, 0);
    tick(3);
    check("t1_count_e3", count_o, 0);
    exp_q.push_back(8'd1);
    tick(1);
    sb_check("t1_count_e4", count_o);
    exp_q.push_back(8'd2);
    tick(4);
    sb_check("t1_count_e8", count_o);

    // Pause with prescaler at 2, hold, resume: phase preserved.
    tick(2);
    check("t3_count_e10", count_o, 2);
    stop = 1'b1;
    tick(1);
    check("t3_paused_state", st_o, 2);
    tick(6);
    stop = 1'b0;
    check("t3_pause_running", run_o, 0);
    check("t3_pause_count", count_o, 2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t3_resume_running", run_o, 1);
    check("t3_resume_count", count_o, 2);
    exp_q.push_back(8'd3);
    tick(1);
    sb_check("t3_count_after_resume", count_o);

    // Start+Stop together: RUN -> PAUSE; IDLE stays IDLE.
    start = 1'b1; stop = 1'b1;
    tick(1);
    check("t4_run_startstop_state", st_o, 2);
    check("t4_run_startstop_running", run_o, 0);
    start = 1'b0; stop = 1'b0; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t4_clear_state", st_o, 0);
    check("t4_clear_count", count_o, 0);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("t4_idle_startstop_state", st_o, 0);
    check("t4_idle_startstop_count", count_o, 0);

    // Mode latched at start, ignored mid-run, retained across Clear.
    mode_in = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t5_mode_latched", mode_o, 1);
    mode_in = 1'b0;
    tick(6);
    check("t5_mode_held", mode_o, 1);
    check("t5_count_mid", count_o, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t5_mode_after_clear", mode_o, 1);
    check("t5_count_after_clear", count_o, 0);
    mode_in = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t5_mode_restart", mode_o, 0);
    check("t5_count_restart", count_o, 0);

    // Run to terminal count: 99 steps of 4 edges = edge 396 after the start edge.
    tick(395);
    check("t2_count_e395", count_o, 98);
    check("t2_done_e395", done_o, 0);
    exp_q.push_back(8'd99);
    tick(1);
    sb_check("t2_count_e396", count_o);
    check("t2_done_pulse", done_o, 1);
`ifdef TIMER_AUTO_RELOAD_EN
    check("t2_expired_reload", exp_o, 0);
    check("t2_running_reload", run_o, 1);
    tick(1);
    check("t2_done_one_cycle", done_o, 0);
    exp_q.push_back(8'd0);
    tick(3);
    sb_check("t2_wrap_e400", count_o);
    check("t2_expired_e400", exp_o, 0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
`else
    check("t2_expired", exp_o, 1);
    check("t2_running_done", run_o, 0);
    tick(1);
    check("t2_done_one_cycle", done_o, 0);
    exp_q.push_back(8'd99);
    tick(19);
    sb_check("t2_hold_99", count_o);
    check("t2_expired_hold", exp_o, 1);
    check("t2_done_hold", done_o, 0);
    mode_in = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t2_restart_count", count_o, 0);
    check("t2_restart_expired", exp_o, 0);
    check("t2_restart_mode", mode_o, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
`endif

    // Reset mid-run at count 50.
    mode_in = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_q.push_back(8'd50);
    tick(200);
    sb_check("t6_count_50", count_o);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_rst_count", count_o, 0);
    check("t6_rst_mode", mode_o, 0);
    check("t6_rst_running", run_o, 0);
    check("t6_rst_expired", exp_o, 0);
    check("t6_rst_done", done_o, 0);

    // TICK_DIV=1 instance steps on every running edge.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_div1_start_count", count1_o, 0);
    check("t6_div1_running", run1_o, 1);
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      tick(1);
      sb_check("t6_div1_step", count1_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
